sram_req_ctrl: RTL

Requester-side controller for the single-port synchronous SRAM used as data memory in the pipelined RISC-Toy core. Converts a valid/ready request stream from the MEM stage into registered SRAM port signals (CSN/WEN/A/DI), captures read data one cycle after the SRAM edge, and returns it in order through a credit-limited response FIFO. Optional read-modify-write support turns byte-masked stores into SRAM read+write pairs.

---
 rtl/sram_req_pkg.sv | 32 +++
 rtl/sram_rsp_fifo.sv | 43 ++++
 rtl/sram_req_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sram_req_pkg.sv
// Shared definitions for sram_req_ctrl: FSM state encoding, byte-merge helper, default widths.
// The merge helper is only used when SRAM_REQ_RMW_EN is defined.
package sram_req_pkg;

    localparam int AW_DEF        = 10;
    localparam int BW_DEF        = 32;
    localparam int RSP_DEPTH_DEF = 4;

    // Widest data path the merge helper supports; callers extend/truncate to their width.
    localparam int MERGE_MAX_BW  = 256;
    localparam int MERGE_MAX_BE  = MERGE_MAX_BW / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RMW_RD   = 2'd1,
        RMW_WAIT = 2'd2,
        RMW_WR   = 2'd3
    } state_t;

    function automatic logic [MERGE_MAX_BW-1:0] byte_merge(
        input logic [MERGE_MAX_BW-1:0] old_data,
        input logic [MERGE_MAX_BW-1:0] new_data,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX_BW-1:0] res;
        for (int i = 0; i < MERGE_MAX_BE; i++) begin
            res[i*8 +: 8] = be[i] ? new_data[i*8 +: 8] : old_data[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO for sram_req_ctrl; cleared by the synchronous active-low reset.
// Output data reads as zero whenever the FIFO is empty.
module sram_rsp_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sram_req_ctrl.sv
// Requester-side controller for a single-port synchronous SRAM: registered port, tagged read capture,
// credit-limited response FIFO. Define SRAM_REQ_RMW_EN to turn partial-BE stores into read+write pairs.
module sram_req_ctrl
    import sram_req_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int BW        = BW_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic            REQ_WE,
    input  logic [AW-1:0]   REQ_ADDR,
    input  logic [BW-1:0]   REQ_WDATA,
    input  logic [BW/8-1:0] REQ_BE,
    output logic            RSP_VALID,
    input  logic            RSP_READY,
    output logic [BW-1:0]   RSP_DATA,
    output logic            MEM_CSN,
    output logic            MEM_WEN,
    output logic [AW-1:0]   MEM_A,
    output logic [BW-1:0]   MEM_DI,
    input  logic [BW-1:0]   MEM_DOUT,
    output logic            BUSY
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] fifo_count;
    logic          tag1, tag2;
    logic          csn_q, wen_q;
    logic [AW-1:0] a_q;
    logic [BW-1:0] di_q;
    logic          accept, rd_accept, wr_accept, wr_full, pop;

    assign REQ_READY = RSTN & (state == IDLE) & (cnt < DEPTH_C);
    assign accept    = REQ_VALID & REQ_READY;
    assign rd_accept = accept & ~REQ_WE;
    // A store with no byte enables is accepted but never reaches the SRAM.
    assign wr_accept = accept & REQ_WE & (|REQ_BE);

`ifdef SRAM_REQ_RMW_EN
    logic          rmw_start;
    logic [BW-1:0] rmw_wdata;
    logic [BW/8-1:0] rmw_be;
    logic [BW-1:0] merged;

    assign wr_full   = wr_accept & (&REQ_BE);
    assign rmw_start = wr_accept & ~(&REQ_BE);
    assign merged    = BW'(byte_merge(MERGE_MAX_BW'(MEM_DOUT), MERGE_MAX_BW'(rmw_wdata),
                                      MERGE_MAX_BE'(rmw_be)));

    always_ff @(posedge CLK) begin
        if (rmw_start) begin
            rmw_wdata <= REQ_WDATA;
            rmw_be    <= REQ_BE;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (rmw_start) state_nxt = RMW_RD;
            RMW_RD:   state_nxt = RMW_WAIT;
            RMW_WAIT: state_nxt = RMW_WR;
            RMW_WR:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end
`else
    assign wr_full = wr_accept;

    always_comb begin
        state_nxt = IDLE;
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            csn_q <= 1'b1;
            wen_q <= 1'b1;
            a_q   <= '0;
            di_q  <= '0;
            tag1  <= 1'b0;
            tag2  <= 1'b0;
            cnt   <= '0;
        end else begin
            csn_q <= 1'b1;
            wen_q <= 1'b1;
            tag1  <= rd_accept;
            tag2  <= tag1;
            cnt   <= cnt + CW'(rd_accept) - CW'(pop);
            if (rd_accept) begin
                csn_q <= 1'b0;
                a_q   <= REQ_ADDR;
            end else if (wr_full) begin
                csn_q <= 1'b0;
                wen_q <= 1'b0;
                a_q   <= REQ_ADDR;
                di_q  <= REQ_WDATA;
`ifdef SRAM_REQ_RMW_EN
            end else if (rmw_start) begin
                csn_q <= 1'b0;
                a_q   <= REQ_ADDR;
            end else if (state == RMW_WAIT) begin
                // a_q still holds the RMW address; old word is on MEM_DOUT this cycle.
                csn_q <= 1'b0;
                wen_q <= 1'b0;
                di_q  <= merged;
`endif
            end
        end
    end

    assign MEM_CSN = csn_q;
    assign MEM_WEN = wen_q;
    assign MEM_A   = a_q;
    assign MEM_DI  = di_q;

    assign RSP_VALID = (fifo_count != '0);
    assign pop       = RSP_VALID & RSP_READY;
    assign BUSY      = tag1 | tag2 | (state != IDLE) | RSP_VALID;

    sram_rsp_fifo #(
        .W     (BW),
        .DEPTH (RSP_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (CLK),
        .rstn      (RSTN),
        .push      (tag2),
        .push_data (MEM_DOUT),
        .pop       (pop),
        .pop_data  (RSP_DATA),
        .count     (fifo_count)
    );

endmodule
